// File: rtl/shifter_pkg.sv
// Shared encodings for the sequential shifter: operation modes and FSM states.
// Mode 11 is a rotate only when SEQ_SHIFTER_ROTATE_EN is defined.
package shifter_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_LSR = 2'b00,
    MODE_LSL = 2'b01,
    MODE_ASR = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One single-bit step of the selected shift mode (purely combinational).
// Rotate logic exists only when SEQ_SHIFTER_ROTATE_EN is defined; otherwise mode 11 acts as LSR.
module shift_step
  import shifter_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] r,
  input  mode_e        mode,
  output logic [N-1:0] q
);

  always_comb begin
    q = {1'b0, r[N-1:1]};
    case (mode)
      MODE_LSL: q = {r[N-2:0], 1'b0};
      MODE_ASR: q = {r[N-1], r[N-1:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
      MODE_ROR: q = {r[0], r[N-1:1]};
`endif
      default:  q = {1'b0, r[N-1:1]};
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: one bit per clock, fixed latency of shamt+1 SHIFT cycles, then a one-cycle done.
// Optional rotate mode is enabled with the SEQ_SHIFTER_ROTATE_EN macro.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [SW-1:0] shamt,
  input  logic [1:0]    mode,
  output logic [N-1:0]  C,
  output logic          busy,
  output logic          done
);

  state_e        state_reg, state_next;
  logic [N-1:0]  work_reg, work_next;
  logic [N-1:0]  c_reg, c_next;
  logic [SW-1:0] cnt_reg, cnt_next;
  mode_e         mode_reg, mode_next;
  logic [N-1:0]  step_q;

  shift_step #(.N(N)) u_step (
    .r    (work_reg),
    .mode (mode_reg),
    .q    (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      work_reg  <= '0;
      c_reg     <= '0;
      cnt_reg   <= '0;
      mode_reg  <= MODE_LSR;
    end else begin
      state_reg <= state_next;
      work_reg  <= work_next;
      c_reg     <= c_next;
      cnt_reg   <= cnt_next;
      mode_reg  <= mode_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    work_next  = work_reg;
    c_next     = c_reg;
    cnt_next   = cnt_reg;
    mode_next  = mode_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          work_next  = A;
          cnt_next   = shamt;
          mode_next  = mode_e'(mode);
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_reg != '0) begin
          work_next = step_q;
          cnt_next  = cnt_reg - SW'(1);
        end else begin
          // C is only updated here, so it stays stable for the whole operation.
          c_next     = work_reg;
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign C = c_reg;

endmodule
